// File: rtl/signal_phase_controller.sv
// Two-approach signal phase controller with min/max green, yellow, all-red and optional protected lefts.
// Optional feature macro: LEFT_TURN_PHASE_EN (enables the NS_LEFT / EW_LEFT phases).
module signal_phase_controller #(
  parameter int MIN_GREEN   = 4,
  parameter int MAX_GREEN   = 10,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2,
  parameter int LEFT_TIME   = 3
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [4:0] n_counter,
  input  logic [4:0] s_counter,
  input  logic [4:0] e_counter,
  input  logic [4:0] w_counter,
  input  logic       ns_left_req,
  input  logic       ew_left_req,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       ns_left_arrow,
  output logic       ew_left_arrow,
  output logic [2:0] phase,
  output logic [7:0] phase_timer,
  output logic       switch_pulse
);

  typedef enum logic [2:0] {
    ALLRED_EW = 3'd0,
    NS_LEFT   = 3'd1,
    NS_GREEN  = 3'd2,
    NS_YELLOW = 3'd3,
    ALLRED_NS = 3'd4,
    EW_LEFT   = 3'd5,
    EW_GREEN  = 3'd6,
    EW_YELLOW = 3'd7
  } state_t;

  localparam logic [7:0] MIN_LAST    = 8'(MIN_GREEN - 1);
  localparam logic [7:0] MAX_LAST    = 8'(MAX_GREEN - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_TIME - 1);
  localparam logic [7:0] LEFT_LAST   = 8'(LEFT_TIME - 1);

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;

  state_t      state_r;
  state_t      next_state_s;
  logic [7:0]  timer_r;
  logic [5:0]  ns_demand_s;
  logic [5:0]  ew_demand_s;
  logic [1:0]  ns_light_s;
  logic [1:0]  ew_light_s;
  logic        ns_arrow_s;
  logic        ew_arrow_s;
  logic        ns_left_go_s;
  logic        ew_left_go_s;

  // Widen before adding so two full 5-bit queues cannot wrap to zero demand.
  assign ns_demand_s = {1'b0, n_counter} + {1'b0, s_counter};
  assign ew_demand_s = {1'b0, e_counter} + {1'b0, w_counter};

`ifdef LEFT_TURN_PHASE_EN
  assign ns_left_go_s = ns_left_req;
  assign ew_left_go_s = ew_left_req;
`else
  logic left_req_unused_s;
  assign left_req_unused_s = ns_left_req | ew_left_req;
  assign ns_left_go_s      = 1'b0;
  assign ew_left_go_s      = 1'b0;
`endif

  // Green ends only with waiting cross traffic, after min green, on gap-out or max-out.
  function automatic logic green_done(input logic [7:0] t, input logic [5:0] own,
                                      input logic [5:0] comp);
    green_done = (t >= MIN_LAST) && (comp != 6'd0) && ((own == 6'd0) || (t >= MAX_LAST));
  endfunction

  // Next-state selection.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ALLRED_EW: begin
        if (timer_r == ALLRED_LAST) begin
          if (ns_left_go_s) next_state_s = NS_LEFT;
          else              next_state_s = NS_GREEN;
        end else begin
          next_state_s = state_r;
        end
      end
      NS_LEFT: begin
        if (timer_r == LEFT_LAST) next_state_s = NS_GREEN;
        else                      next_state_s = state_r;
      end
      NS_GREEN: begin
        if (green_done(timer_r, ns_demand_s, ew_demand_s)) next_state_s = NS_YELLOW;
        else                                                next_state_s = state_r;
      end
      NS_YELLOW: begin
        if (timer_r == YELLOW_LAST) next_state_s = ALLRED_NS;
        else                        next_state_s = state_r;
      end
      ALLRED_NS: begin
        if (timer_r == ALLRED_LAST) begin
          if (ew_left_go_s) next_state_s = EW_LEFT;
          else              next_state_s = EW_GREEN;
        end else begin
          next_state_s = state_r;
        end
      end
      EW_LEFT: begin
        if (timer_r == LEFT_LAST) next_state_s = EW_GREEN;
        else                      next_state_s = state_r;
      end
      EW_GREEN: begin
        if (green_done(timer_r, ew_demand_s, ns_demand_s)) next_state_s = EW_YELLOW;
        else                                                next_state_s = state_r;
      end
      EW_YELLOW: begin
        if (timer_r == YELLOW_LAST) next_state_s = ALLRED_EW;
        else                        next_state_s = state_r;
      end
      default: next_state_s = ALLRED_EW;
    endcase
  end

  // Output decode of the upcoming state, registered below so outputs track the state register.
  always_comb begin
    ns_light_s = LIGHT_RED;
    ew_light_s = LIGHT_RED;
    ns_arrow_s = 1'b0;
    ew_arrow_s = 1'b0;
    case (next_state_s)
      NS_LEFT:   ns_arrow_s = 1'b1;
      NS_GREEN:  ns_light_s = LIGHT_GREEN;
      NS_YELLOW: ns_light_s = LIGHT_YELLOW;
      EW_LEFT:   ew_arrow_s = 1'b1;
      EW_GREEN:  ew_light_s = LIGHT_GREEN;
      EW_YELLOW: ew_light_s = LIGHT_YELLOW;
      default: begin
        ns_light_s = LIGHT_RED;
        ew_light_s = LIGHT_RED;
      end
    endcase
  end

  // State, saturating phase timer and registered outputs.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_r       <= ALLRED_EW;
      timer_r       <= 8'd0;
      ns_light      <= LIGHT_RED;
      ew_light      <= LIGHT_RED;
      ns_left_arrow <= 1'b0;
      ew_left_arrow <= 1'b0;
      switch_pulse  <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      ns_light      <= ns_light_s;
      ew_light      <= ew_light_s;
      ns_left_arrow <= ns_arrow_s;
      ew_left_arrow <= ew_arrow_s;
      switch_pulse  <= (next_state_s != state_r);
      if (next_state_s != state_r) timer_r <= 8'd0;
      else if (timer_r != 8'd255)  timer_r <= timer_r + 8'd1;
      else                         timer_r <= timer_r;
    end
  end

  assign phase       = state_r;
  assign phase_timer = timer_r;

endmodule

// File: doc/signal_phase_controller.md
SIGNAL_PHASE_CONTROLLER -- requirements
Module: signal_phase_controller

Interface
REQ-001 SHALL have parameter MIN_GREEN, default 4, minimum green cycles per through phase.
REQ-002 SHALL have parameter MAX_GREEN, default 10, green cycles after which a phase is forced off when competing demand exists.
REQ-003 SHALL have parameter YELLOW_TIME, default 3, yellow duration in cycles.
REQ-004 SHALL have parameter ALLRED_TIME, default 2, all-red clearance duration in cycles.
REQ-005 SHALL have parameter LEFT_TIME, default 3, protected-left duration in cycles.
REQ-006 SHALL have one clock; reset is synchronous and active-low.
REQ-007 SHALL have port CLK, input, 1 bit, rising-edge clock.
REQ-008 SHALL have port rst, input, 1 bit, synchronous active-low reset.
REQ-009 SHALL have ports n_counter, s_counter, e_counter, w_counter, input, 5 bits each, queued cars per approach from traffic_signal.
REQ-010 SHALL have ports ns_left_req and ew_left_req, input, 1 bit each, left-turn demand.
REQ-011 SHALL have ports ns_light and ew_light, output, 2 bits each, encoded 00 red, 01 green, 10 yellow.
REQ-012 SHALL have ports ns_left_arrow and ew_left_arrow, output, 1 bit each, protected-left arrow.
REQ-013 SHALL have port phase, output, 3 bits, current state code.
REQ-014 SHALL have port phase_timer, output, 8 bits, cycles elapsed in the current state.
REQ-015 SHALL have port switch_pulse, output, 1 bit, one-cycle pulse on the first cycle of every new state.

Function
REQ-016 SHALL compute ns_demand = n_counter + s_counter and ew_demand = e_counter + w_counter, each 6 bits with no overflow.
REQ-017 SHALL implement states with phase codes ALLRED_EW=0, NS_LEFT=1, NS_GREEN=2, NS_YELLOW=3, ALLRED_NS=4, EW_LEFT=5, EW_GREEN=6, EW_YELLOW=7.
REQ-018 SHALL clear phase_timer to 0 on every state entry, increment it each cycle and saturate it at 255.
REQ-019 SHALL exit fixed-length states (yellow, all-red, left) when phase_timer == duration-1, so each lasts exactly its duration.
REQ-020 SHALL run the cycle ALLRED_EW -> [NS_LEFT] -> NS_GREEN -> NS_YELLOW -> ALLRED_NS -> [EW_LEFT] -> EW_GREEN -> EW_YELLOW -> ALLRED_EW.
REQ-021 SHALL end a green state only when phase_timer >= MIN_GREEN-1 AND competing demand > 0 AND (own demand == 0 OR phase_timer >= MAX_GREEN-1).
REQ-022 SHALL hold a green state indefinitely (rest-in-green) while competing demand == 0, regardless of MAX_GREEN.
REQ-023 SHALL drive exactly one approach pair non-red at a time; in the ALLRED_* states both lights SHALL be 00.
REQ-024 SHALL drive the left arrow high only in the matching LEFT state, with the through light of that pair at 00 during it.
REQ-025 SHALL sample the demand and left-request inputs at each clock edge; a change during a fixed-length state SHALL NOT alter that state's duration.
REQ-026 SHALL register all outputs, with outputs reflecting the new state in the cycle after the transition edge.

Reset
REQ-027 SHALL, on any rising CLK edge with rst=0 (including mid-phase), enter ALLRED_EW with phase_timer=0, both lights 00, both arrows 0, and switch_pulse=0.
REQ-028 SHALL, on the first edge with rst=1, begin counting in ALLRED_EW, so the first green is NS after ALLRED_TIME cycles.

Configuration
REQ-029 SHALL, with LEFT_TURN_PHASE_EN defined, insert NS_LEFT after ALLRED_EW when ns_left_req=1 at exit and EW_LEFT after ALLRED_NS when ew_left_req=1, and otherwise skip the LEFT state.
REQ-030 SHALL, with LEFT_TURN_PHASE_EN undefined, keep the left ports present but ignored, never enter the LEFT states, and hold both arrows at 0.

Verification
REQ-031 SHALL verify reset: rst=0 for 2 edges during EW_GREEN -> phase=0, lights 00/00, phase_timer=0; release -> ns_light=01 after 2 cycles.
REQ-032 SHALL verify rest-in-green: ns counters=3, e/w=0 for 50 cycles -> ns_light stays 01 and phase_timer reaches 49.
REQ-033 SHALL verify gap-out: n=s=0, e=1 from entry -> NS green lasts 4 cycles, then yellow 3 cycles, all-red 2 cycles, then ew_light=01.
REQ-034 SHALL verify max-out: n=s=5 and e=w=5 held constant -> each green lasts exactly 10 cycles, and the full cycle is 30 cycles.
REQ-035 SHALL verify the left phase with LEFT_TURN_PHASE_EN defined: ns_left_req=1 -> ns_left_arrow=1 for 3 cycles between ALLRED_EW and NS_GREEN; with the macro undefined -> the arrow is never 1.
REQ-036 SHALL verify the safety invariant every cycle: never ns_light!=00 and ew_light!=00 simultaneously, and switch_pulse exactly once per state entry.
